multicycle_control: RTL and testbench

Multi-cycle MIPS control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and writeback states, driving the datapath muxes and write strobes. It is the successor to the single-cycle decoder and adds these behaviours:
- variable-latency memory via a req/ready handshake, with a wait-state timeout
- illegal-opcode and bus-error trapping
- a retired-instruction counter
- optional `jal` support

It sits between the instruction register's opcode field and the multi-cycle datapath.

---
 rtl/multicycle_control.sv | 266 ++++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
//
// Moore FSM control unit for a multi-cycle MIPS datapath. Each instruction
// is sequenced through fetch, decode, execute, memory and writeback states.
// Memory accesses use a req/ready handshake with an optional wait-state
// timeout. Illegal opcodes and memory timeouts park the FSM in TRAP until
// reset.
//
// Optional feature: define MC_JAL_EN to decode opcode 000011 (jal) into the
// JAL state. Without it, jal traps as an illegal opcode.
//
// Parameters:
//   RET_W        width of the retired-instruction counter
//   MEM_TIMEOUT  max consecutive wait cycles per memory access (0 = off)
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   opcode[5:0]                  IR[31:26], stable from DECODE to next FETCH
//   mem_ready                    memory completes the access this cycle
//   mem_req, mem_read, mem_write memory request and access type
//   i_or_d                       0 = PC address, 1 = ALUOut address
//   ir_write, pc_write,
//   pc_write_cond, reg_write     datapath write strobes
//   reg_dst[1:0]                 00 rt, 01 rd, 10 $31
//   mem_to_reg[1:0]              00 ALUOut, 01 MDR, 10 PC
//   alu_src_a                    0 PC, 1 A
//   alu_src_b[1:0]               00 B, 01 4, 10 imm, 11 imm<<2
//   alu_op[1:0]                  00 add, 01 sub, 10 funct
//   pc_source[1:0]               00 ALU result, 01 ALUOut, 10 jump target
//   state[3:0]                   current state encoding
//   illegal_op, bus_err          sticky trap causes
//   retired[RET_W-1:0]           instructions completed (wraps)
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int RET_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             bus_err,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_RD    = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WR    = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        ADDI_EXEC = 4'd10,
        ADDI_WB   = 4'd11,
        JAL       = 4'd12,
        TRAP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // Wait counter only needs to reach MEM_TIMEOUT-1 before the trap fires.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t            state_q, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    // Ungated request; the exported strobes are additionally forced low in reset.
    logic              req_c;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // signal unassigned; an incomplete assignment here would infer a latch.
        state_next    = state_q;
        req_c         = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'b00;
        mem_to_reg    = 2'b00;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;

        unique case (state_q)
            FETCH: begin
                req_c     = 1'b1;
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) state_next = DECODE;
            end
            DECODE: begin
                alu_src_b = 2'b11;
                unique case (opcode)
                    OP_RTYPE:      state_next = R_EXEC;
                    OP_LW, OP_SW:  state_next = MEM_ADDR;
                    OP_BEQ:        state_next = BRANCH;
                    OP_J:          state_next = JUMP;
                    OP_ADDI:       state_next = ADDI_EXEC;
`ifdef MC_JAL_EN
                    OP_JAL:        state_next = JAL;
`endif
                    default:       state_next = TRAP;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                req_c    = 1'b1;
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_next = MEM_WB;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'b01;
                state_next = FETCH;
            end
            MEM_WR: begin
                req_c     = 1'b1;
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_next = FETCH;
            end
            R_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = R_WB;
            end
            R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 2'b01;
                state_next = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                state_next    = FETCH;
            end
            JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = FETCH;
            end
            ADDI_EXEC: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                state_next = ADDI_WB;
            end
            ADDI_WB: begin
                reg_write  = 1'b1;
                state_next = FETCH;
            end
`ifdef MC_JAL_EN
            JAL: begin
                // PC already holds PC+4 here, so $31 gets the return address.
                reg_write  = 1'b1;
                reg_dst    = 2'b10;
                mem_to_reg = 2'b10;
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                state_next = FETCH;
            end
`endif
            default: begin
                // TRAP and any unreachable encoding: all strobes low, held.
                state_next = TRAP;
            end
        endcase

        // A ready on the final allowed wait cycle still completes the access,
        // so the trap only fires when this cycle is itself another wait.
        timeout_hit = (MEM_TIMEOUT != 0) && req_c && !mem_ready &&
                      (wait_cnt == WAIT_LAST);
        if (timeout_hit) state_next = TRAP;

        // NOTE: reset is asynchronous, so the strobes are masked combinationally
        // while rst_n is low; the mux selects keep their FETCH values.
        if (!rst_n) begin
            mem_read  = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
        end
    end

    assign mem_req = req_c & rst_n;
    assign state   = state_q;

    // -----------------------------------------------------------------------
    // State, wait counter, retired counter and sticky trap flags
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            wait_cnt   <= '0;
            retired    <= '0;
            illegal_op <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples the
            // pre-edge values, independent of statement order.
            state_q <= state_next;

            // Any state change restarts the count, covering entry to
            // FETCH, MEM_RD and MEM_WR.
            if (state_next != state_q)
                wait_cnt <= '0;
            else if (req_c && !mem_ready)
                wait_cnt <= wait_cnt + WAIT_W'(1);

            if (state_q != FETCH && state_next == FETCH)
                retired <= retired + RET_W'(1);

            if (state_q == DECODE && state_next == TRAP)
                illegal_op <= 1'b1;

            if (timeout_hit)
                bus_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control
//
// Directed-vector bench for multicycle_control. Each cycle applies opcode and
// mem_ready shortly after the rising edge, lets the combinational outputs
// settle, then compares the state and selected outputs against hand-computed
// values before advancing to the next edge.
// ---------------------------------------------------------------------------
module tb_multicycle_control;

    localparam int RET_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = 6'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_read, mem_write, i_or_d;
    logic             ir_write, pc_write, pc_write_cond, reg_write;
    logic [1:0]       reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
    logic             alu_src_a;
    logic [3:0]       state;
    logic             illegal_op, bus_err;
    logic [RET_W-1:0] retired;

    int total = 0;
    int bad   = 0;

    multicycle_control #(.RET_W(RET_W), .MEM_TIMEOUT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .i_or_d       (i_or_d),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_write_cond(pc_write_cond),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .alu_op       (alu_op),
        .pc_source    (pc_source),
        .state        (state),
        .illegal_op   (illegal_op),
        .bus_err      (bus_err),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for this cycle, settle, check the state (no edge taken).
    task automatic at(input string tag, input logic rdy, input logic [5:0] op,
                      input logic [3:0] exp_state);
        mem_ready = rdy;
        opcode    = op;
        #1;
        check(tag, 32'(state), 32'(exp_state));
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic rdy, input logic [5:0] op,
                        input logic [3:0] exp_state);
        at(tag, rdy, op, exp_state);
        adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        adv();
        rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- Reset state ----------------
        mem_ready = 1'b1;
        #2;
        check("rst_state", 32'(state), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ir_write", 32'(ir_write), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_alu_src_b", 32'(alu_src_b), 32'd1);
        check("rst_retired", retired, 32'd0);
        check("rst_flags", 32'({illegal_op, bus_err}), 32'd0);
        adv();
        adv();
        rst_n = 1'b1;

        // ---------------- add: 0,1,6,7,0 ----------------
        at("add_f", 1'b1, 6'b000000, 4'd0);
        check("add_f_ir_write", 32'(ir_write), 32'd1);
        check("add_f_mem_req", 32'(mem_req), 32'd1);
        adv();
        step("add_d", 1'b1, 6'b000000, 4'd1);
        at("add_ex", 1'b1, 6'b000000, 4'd6);
        check("add_ex_alu_op", 32'(alu_op), 32'd2);
        adv();
        at("add_wb", 1'b1, 6'b000000, 4'd7);
        check("add_wb_reg_write", 32'(reg_write), 32'd1);
        check("add_wb_reg_dst", 32'(reg_dst), 32'd1);
        adv();
        check("add_retired", retired, 32'd1);

        // ---------------- lw with 3 data wait cycles (8 cycles) ----------------
        step("lw_f", 1'b1, 6'b100011, 4'd0);
        step("lw_d", 1'b1, 6'b100011, 4'd1);
        step("lw_addr", 1'b1, 6'b100011, 4'd2);
        for (int i = 0; i < 3; i++) begin
            at("lw_rd_wait", 1'b0, 6'b100011, 4'd3);
            check("lw_rd_i_or_d", 32'(i_or_d), 32'd1);
            adv();
        end
        step("lw_rd_done", 1'b1, 6'b100011, 4'd3);
        at("lw_wb", 1'b1, 6'b100011, 4'd4);
        check("lw_wb_mem_to_reg", 32'(mem_to_reg), 32'd1);
        check("lw_wb_reg_write", 32'(reg_write), 32'd1);
        adv();
        at("lw_back", 1'b1, 6'b100011, 4'd0);
        check("lw_retired", retired, 32'd2);

        // ---------------- beq, sw, j back-to-back ----------------
        adv();
        step("beq_d", 1'b1, 6'b000100, 4'd1);
        at("beq_br", 1'b1, 6'b000100, 4'd8);
        check("beq_pc_write_cond", 32'(pc_write_cond), 32'd1);
        check("beq_pc_source", 32'(pc_source), 32'd1);
        check("beq_alu_op", 32'(alu_op), 32'd1);
        adv();
        at("sw_f", 1'b1, 6'b101011, 4'd0);
        check("sw_f_pc_write_cond", 32'(pc_write_cond), 32'd0);
        adv();
        step("sw_d", 1'b1, 6'b101011, 4'd1);
        step("sw_addr", 1'b1, 6'b101011, 4'd2);
        at("sw_wr", 1'b1, 6'b101011, 4'd5);
        check("sw_mem_write", 32'(mem_write), 32'd1);
        check("sw_mem_read", 32'(mem_read), 32'd0);
        adv();
        step("j_f", 1'b1, 6'b000010, 4'd0);
        step("j_d", 1'b1, 6'b000010, 4'd1);
        at("j_jump", 1'b1, 6'b000010, 4'd9);
        check("j_pc_write", 32'(pc_write), 32'd1);
        check("j_pc_source", 32'(pc_source), 32'd2);
        adv();
        at("j_back", 1'b1, 6'b000010, 4'd0);
        check("bsj_retired", retired, 32'd5);

        // ---------------- addi ----------------
        adv();
        step("addi_d", 1'b1, 6'b001000, 4'd1);
        at("addi_ex", 1'b1, 6'b001000, 4'd10);
        check("addi_alu_src_b", 32'(alu_src_b), 32'd2);
        adv();
        at("addi_wb", 1'b1, 6'b001000, 4'd11);
        check("addi_reg_dst", 32'(reg_dst), 32'd0);
        check("addi_mem_to_reg", 32'(mem_to_reg), 32'd0);
        adv();

        // ---------------- fetch timeout near miss: ready on 16th cycle ----------------
        for (int i = 0; i < 15; i++) begin
            at("tmo_ok_wait", 1'b0, 6'b000000, 4'd0);
            check("tmo_ok_ir_write", 32'(ir_write), 32'd0);
            adv();
        end
        step("tmo_ok_last", 1'b1, 6'b000000, 4'd0);
        at("tmo_ok_decode", 1'b1, 6'b000000, 4'd1);
        check("tmo_ok_bus_err", 32'(bus_err), 32'd0);
        check("tmo_ok_retired", retired, 32'd6);
        adv();
        step("tmo_ok_ex", 1'b1, 6'b000000, 4'd6);
        step("tmo_ok_wb", 1'b1, 6'b000000, 4'd7);

        // ---------------- jal (macro dependent) ----------------
        step("jal_f", 1'b1, 6'b000011, 4'd0);
        step("jal_d", 1'b1, 6'b000011, 4'd1);
`ifdef MC_JAL_EN
        at("jal_state", 1'b1, 6'b000011, 4'd12);
        check("jal_reg_dst", 32'(reg_dst), 32'd2);
        check("jal_mem_to_reg", 32'(mem_to_reg), 32'd2);
        check("jal_pc_write", 32'(pc_write), 32'd1);
        adv();
        at("jal_back", 1'b1, 6'b000011, 4'd0);
        check("jal_retired", retired, 32'd8);
`else
        at("jal_trap", 1'b1, 6'b000011, 4'd13);
        check("jal_illegal", 32'(illegal_op), 32'd1);
`endif
        do_reset();

        // ---------------- illegal opcode 111111 ----------------
        step("ill_f", 1'b1, 6'b111111, 4'd0);
        step("ill_d", 1'b1, 6'b111111, 4'd1);
        for (int i = 0; i < 10; i++) begin
            at("ill_hold", 1'b1, 6'b111111, 4'd13);
            adv();
        end
        check("ill_illegal_op", 32'(illegal_op), 32'd1);
        check("ill_bus_err", 32'(bus_err), 32'd0);
        check("ill_mem_req", 32'(mem_req), 32'd0);
        // Asynchronous reset away from any edge.
        rst_n = 1'b0;
        #1;
        check("ill_rst_state", 32'(state), 32'd0);
        check("ill_rst_illegal", 32'(illegal_op), 32'd0);
        check("ill_rst_retired", retired, 32'd0);
        check("ill_rst_mem_req", 32'(mem_req), 32'd0);
        adv();
        rst_n = 1'b1;

        // ---------------- fetch timeout: 16 waits -> TRAP ----------------
        for (int i = 0; i < 16; i++) begin
            at("tmo_wait", 1'b0, 6'b000000, 4'd0);
            adv();
        end
        at("tmo_trap", 1'b0, 6'b000000, 4'd13);
        check("tmo_bus_err", 32'(bus_err), 32'd1);
        check("tmo_illegal", 32'(illegal_op), 32'd0);
        do_reset();

        // ---------------- data-read timeout and mid-instruction reset ----------------
        step("dtmo_f", 1'b1, 6'b100011, 4'd0);
        step("dtmo_d", 1'b1, 6'b100011, 4'd1);
        step("dtmo_addr", 1'b1, 6'b100011, 4'd2);
        for (int i = 0; i < 16; i++) begin
            at("dtmo_wait", 1'b0, 6'b100011, 4'd3);
            adv();
        end
        at("dtmo_trap", 1'b0, 6'b100011, 4'd13);
        check("dtmo_bus_err", 32'(bus_err), 32'd1);
        do_reset();
        step("mid_f", 1'b1, 6'b000000, 4'd0);
        at("mid_d", 1'b1, 6'b000000, 4'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        adv();
        rst_n = 1'b1;
        at("mid_refetch", 1'b1, 6'b000000, 4'd0);
        adv();
        at("mid_decode", 1'b1, 6'b000000, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
